nf_hazard_unit_p: RTL and testbench
===================================

Name: nf_hazard_unit_p

Overview:
Parametrised, stateful hazard unit for the 5-stage nanoFOX pipeline (IF/ID/EXE/MEM/WB).
- Generates EXE-stage operand bypass selects with x0 suppression.
- Stalls only on true load-use hazards; non-load producers are handled by bypass.
- Freezes the whole pipeline while the load/store unit is busy, with a timeout watchdog.
- Holds a pending branch flush across a memory wait.

Parameters:
AW, 5, register-file address width
LSU_TMO, 64, max MEM_WAIT cycles before timeout (>=2)
CW, 7, width of wait counter (must hold LSU_TMO-1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
wa3_imem  input  AW  MEM-stage destination register
we_rf_imem  input  1  MEM-stage RF write enable
wa3_iwb  input  AW  WB-stage destination register
we_rf_iwb  input  1  WB-stage RF write enable
ra1_iexe  input  AW  EXE-stage source 1
ra2_iexe  input  AW  EXE-stage source 2
rd1_bypass  output  2  source-1 bypass select
rd2_bypass  output  2  source-2 bypass select
wa3_iexe  input  AW  EXE-stage destination register
we_rf_iexe  input  1  EXE-stage RF write enable
load_iexe  input  1  EXE-stage instruction is a load
ra1_id  input  AW  ID-stage source 1
ra2_id  input  AW  ID-stage source 2
branch_taken  input  1  EXE-stage branch/jump resolved taken
lsu_busy  input  1  data-memory access outstanding
stall_if  output  1  hold PC (active-high)
stall_id  output  1  hold IF/ID register
stall_iexe  output  1  hold ID/EXE register
stall_imem  output  1  hold EXE/MEM register
flush_iid  output  1  bubble IF/ID register
flush_iexe  output  1  bubble ID/EXE register
lsu_tmo  output  1  LSU timeout flag

Behaviour:
- Reset (async, rst=1): state=RUN, wait_cnt=0, flush_pend=0, lsu_tmo=0. With lsu_busy=0 and branch_taken=0, all stall/flush outputs are 0.
- Reset mid-MEM_WAIT: returns to RUN and drops any pending flush.
- Bypass (combinational, all states), per source ra:
  - 2'b01 (MEM) if ra!=0 & we_rf_imem & wa3_imem==ra.
  - else 2'b10 (WB) if ra!=0 & we_rf_iwb & wa3_iwb==ra.
  - else 2'b00 (NONE).
  - MEM has priority over WB. Register 0 never bypasses.
- lu (load-use hazard) = we_rf_iexe & load_iexe & wa3_iexe!=0 & (ra1_id==wa3_iexe | ra2_id==wa3_iexe).
- FSM states: RUN, MEM_WAIT, TMO.
- RUN:
  - If lsu_busy: all four stalls=1 this cycle, no flushes; branch_taken sets flush_pend; next state MEM_WAIT, wait_cnt=0.
  - Else if branch_taken or flush_pend: flush_iid=1, flush_iexe=1, stalls=0, flush_pend cleared. A branch takes priority over lu in the same cycle.
  - Else if lu: stall_if=1, stall_id=1, flush_iexe=1 for exactly one cycle. The hazard clears once the bubble advances.
  - Else: all outputs 0.
- MEM_WAIT:
  - All four stalls=1, flushes=0; wait_cnt increments each cycle; branch_taken sets flush_pend.
  - If lsu_busy=0: next RUN. The pending flush fires in that first RUN cycle.
  - If lsu_busy=1 and wait_cnt==LSU_TMO-1: next TMO.
- TMO:
  - lsu_tmo=1 (registered, from state); stalls released; flush_pend kept.
  - Next RUN when lsu_busy=0; lsu_tmo deasserts in that RUN cycle.
- Counter saturates at LSU_TMO-1 and is cleared on every entry to MEM_WAIT.
- All stall/flush outputs are combinational from state and inputs (zero latency). lsu_tmo has one-cycle latency from its transition.

Optional Feature:
NF_HU_PERF_CNT_EN:
- Defined: adds outputs lu_stall_cnt[31:0] and mem_stall_cnt[31:0].
  - lu_stall_cnt increments on each cycle in which the lu stall is applied.
  - mem_stall_cnt increments on each cycle with stall_imem=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and registers absent; all other behaviour is identical.

Test Plan:
- Bypass priority: we_rf_imem=1, we_rf_iwb=1, wa3_imem=wa3_iwb=ra1_iexe=5 -> rd1_bypass=2'b01; repeat with ra1_iexe=0 -> 2'b00.
- Load-use: load_iexe=1, we_rf_iexe=1, wa3_iexe=3, ra2_id=3 -> stall_if=stall_id=flush_iexe=1 for one cycle. Same with load_iexe=0 -> all outputs 0.
- Memory wait: lsu_busy high for 4 cycles -> all stalls=1 for exactly 4 cycles. branch_taken pulsed in cycle 2 -> flush_iid=flush_iexe=1 in the first cycle after lsu_busy falls, then 0.
- Timeout (LSU_TMO=64): lsu_busy held 100 cycles -> stalls=1 for 65 cycles (entry cycle + 64 MEM_WAIT), then lsu_tmo=1 with stalls=0 until lsu_busy falls; lsu_tmo=0 the next cycle.
- Branch vs load-use: branch_taken=1 with an lu condition true -> flush_iid=flush_iexe=1, stall_if=stall_id=0.
- Async reset asserted mid-MEM_WAIT with flush_pend set -> outputs 0 immediately. After release with lsu_busy=0, no flush fires.

Source files
------------

// File: rtl/nf_hazard_unit_p_if.sv
// Hazard-unit bus for the nanoFOX pipeline: pipeline-stage register
// addresses/enables in, bypass selects and stall/flush controls out.
// Optional NF_HU_PERF_CNT_EN adds the performance counter outputs.
interface nf_hazard_unit_p_if #(
   parameter int AW = 5
);
   logic [AW-1:0] wa3_imem;
   logic          we_rf_imem;
   logic [AW-1:0] wa3_iwb;
   logic          we_rf_iwb;
   logic [AW-1:0] ra1_iexe;
   logic [AW-1:0] ra2_iexe;
   logic [1:0]    rd1_bypass;
   logic [1:0]    rd2_bypass;
   logic [AW-1:0] wa3_iexe;
   logic          we_rf_iexe;
   logic          load_iexe;
   logic [AW-1:0] ra1_id;
   logic [AW-1:0] ra2_id;
   logic          branch_taken;
   logic          lsu_busy;
   logic          stall_if;
   logic          stall_id;
   logic          stall_iexe;
   logic          stall_imem;
   logic          flush_iid;
   logic          flush_iexe;
   logic          lsu_tmo;
`ifdef NF_HU_PERF_CNT_EN
   logic [31:0]   lu_stall_cnt;
   logic [31:0]   mem_stall_cnt;
`endif

   // pipeline side: drives stage information, consumes hazard controls
   modport master (
`ifdef NF_HU_PERF_CNT_EN
      input  lu_stall_cnt, mem_stall_cnt,
`endif
      output wa3_imem, we_rf_imem, wa3_iwb, we_rf_iwb, ra1_iexe, ra2_iexe,
      output wa3_iexe, we_rf_iexe, load_iexe, ra1_id, ra2_id,
      output branch_taken, lsu_busy,
      input  rd1_bypass, rd2_bypass, stall_if, stall_id, stall_iexe,
      input  stall_imem, flush_iid, flush_iexe, lsu_tmo
   );

   // hazard unit side
   modport slave (
`ifdef NF_HU_PERF_CNT_EN
      output lu_stall_cnt, mem_stall_cnt,
`endif
      input  wa3_imem, we_rf_imem, wa3_iwb, we_rf_iwb, ra1_iexe, ra2_iexe,
      input  wa3_iexe, we_rf_iexe, load_iexe, ra1_id, ra2_id,
      input  branch_taken, lsu_busy,
      output rd1_bypass, rd2_bypass, stall_if, stall_id, stall_iexe,
      output stall_imem, flush_iid, flush_iexe, lsu_tmo
   );
endinterface

// File: rtl/nf_hazard_unit_p.sv
// nanoFOX 5-stage pipeline hazard unit: EXE operand bypass selects,
// load-use stall, whole-pipeline freeze while the LSU is busy (with a
// timeout watchdog) and a branch flush held pending across a memory wait.
// Optional macro NF_HU_PERF_CNT_EN adds lu/mem stall cycle counters.
module nf_hazard_unit_p #(
   parameter int AW      = 5,
   parameter int LSU_TMO = 64,
   parameter int CW      = 7
) (
   input logic           clk,
   input logic           rst,
   nf_hazard_unit_p_if.slave hu
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, TMO} state_t;

   localparam logic [CW-1:0] CNT_MAX = CW'(LSU_TMO - 1);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          flush_pend;
   logic          lu;
   logic          stall_all;
   logic          stall_lu;
   logic          flush_both;
   logic          flush_lu;

   // bypass select for one source: MEM wins over WB, x0 never forwards
   function automatic logic [1:0] byp_sel(input logic [AW-1:0] ra,
                                          input logic           we_mem,
                                          input logic [AW-1:0]  wa_mem,
                                          input logic           we_wb,
                                          input logic [AW-1:0]  wa_wb);
      if ((ra != '0) && we_mem && (wa_mem == ra))
         return 2'b01;
      else if ((ra != '0) && we_wb && (wa_wb == ra))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // operand bypass selects, independent of FSM state
   always_comb begin
      hu.rd1_bypass = byp_sel(hu.ra1_iexe, hu.we_rf_imem, hu.wa3_imem,
                              hu.we_rf_iwb, hu.wa3_iwb);
      hu.rd2_bypass = byp_sel(hu.ra2_iexe, hu.we_rf_imem, hu.wa3_imem,
                              hu.we_rf_iwb, hu.wa3_iwb);
   end

   // true load-use hazard between the EXE load and the ID consumer
   always_comb begin
      lu = hu.we_rf_iexe && hu.load_iexe && (hu.wa3_iexe != '0) &&
           ((hu.ra1_id == hu.wa3_iexe) || (hu.ra2_id == hu.wa3_iexe));
   end

   // stall/flush decode; the freeze tracks lsu_busy so the pipeline
   // restarts in the very cycle the memory access completes
   always_comb begin
      stall_all  = 1'b0;
      stall_lu   = 1'b0;
      flush_both = 1'b0;
      flush_lu   = 1'b0;
      case (state)
         RUN: begin
            if (hu.lsu_busy)
               stall_all = 1'b1;
            else if (hu.branch_taken || flush_pend)
               flush_both = 1'b1;
            else if (lu) begin
               stall_lu = 1'b1;
               flush_lu = 1'b1;
            end
         end
         MEM_WAIT: stall_all = hu.lsu_busy;
         default:  ;
      endcase
      hu.stall_if   = stall_all | stall_lu;
      hu.stall_id   = stall_all | stall_lu;
      hu.stall_iexe = stall_all;
      hu.stall_imem = stall_all;
      hu.flush_iid  = flush_both;
      hu.flush_iexe = flush_both | flush_lu;
   end

   // control FSM with wait counter, pending flush and registered timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         wait_cnt   <= '0;
         flush_pend <= 1'b0;
         hu.lsu_tmo <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hu.lsu_busy) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
                  if (hu.branch_taken)
                     flush_pend <= 1'b1;
               end else if (hu.branch_taken || flush_pend) begin
                  flush_pend <= 1'b0;
               end
            end
            MEM_WAIT: begin
               if (wait_cnt != CNT_MAX)
                  wait_cnt <= wait_cnt + 1'b1;
               if (hu.branch_taken)
                  flush_pend <= 1'b1;
               if (!hu.lsu_busy) begin
                  state <= RUN;
               end else if (wait_cnt == CNT_MAX) begin
                  state      <= TMO;
                  hu.lsu_tmo <= 1'b1;
               end
            end
            TMO: begin
               if (hu.branch_taken)
                  flush_pend <= 1'b1;
               if (!hu.lsu_busy) begin
                  state      <= RUN;
                  hu.lsu_tmo <= 1'b0;
               end
            end
            default: begin
               state      <= RUN;
               hu.lsu_tmo <= 1'b0;
            end
         endcase
      end
   end

`ifdef NF_HU_PERF_CNT_EN
   logic [31:0] lu_cnt;
   logic [31:0] mem_cnt;

   // saturating stall-cycle counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_cnt  <= '0;
         mem_cnt <= '0;
      end else begin
         if (stall_lu && (lu_cnt != 32'hFFFF_FFFF))
            lu_cnt <= lu_cnt + 32'd1;
         if (stall_all && (mem_cnt != 32'hFFFF_FFFF))
            mem_cnt <= mem_cnt + 32'd1;
      end
   end

   assign hu.lu_stall_cnt  = lu_cnt;
   assign hu.mem_stall_cnt = mem_cnt;
`endif

endmodule

// File: tb/tb_nf_hazard_unit_p.sv
// Directed self-checking bench for nf_hazard_unit_p (default parameters).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_nf_hazard_unit_p;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   n_stall;
   int   n_tmo;

   nf_hazard_unit_p_if #(.AW(5)) hif ();

   nf_hazard_unit_p dut (
      .clk (clk),
      .rst (rst),
      .hu  (hif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      hif.wa3_imem = '0; hif.we_rf_imem = 1'b0;
      hif.wa3_iwb = '0; hif.we_rf_iwb = 1'b0;
      hif.ra1_iexe = '0; hif.ra2_iexe = '0;
      hif.wa3_iexe = '0; hif.we_rf_iexe = 1'b0; hif.load_iexe = 1'b0;
      hif.ra1_id = '0; hif.ra2_id = '0;
      hif.branch_taken = 1'b0; hif.lsu_busy = 1'b0;
   endtask

   // packs {stall_if,stall_id,stall_iexe,stall_imem,flush_iid,flush_iexe}
   function automatic logic [31:0] ctl();
      return {26'd0, hif.stall_if, hif.stall_id, hif.stall_iexe,
              hif.stall_imem, hif.flush_iid, hif.flush_iexe};
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #1;
      chk("reset_ctl", ctl(), 32'h00);
      chk("reset_tmo", {31'd0, hif.lsu_tmo}, 32'd0);
      cyc(); cyc();
      rst = 1'b0;

      // bypass selects
      cyc();
      hif.we_rf_imem = 1'b1; hif.we_rf_iwb = 1'b1;
      hif.wa3_imem = 5'd5; hif.wa3_iwb = 5'd5; hif.ra1_iexe = 5'd5;
      #1 chk("byp_mem_prio", {30'd0, hif.rd1_bypass}, 32'h1);
      hif.ra1_iexe = 5'd0; hif.wa3_imem = 5'd0; hif.wa3_iwb = 5'd0;
      #1 chk("byp_x0", {30'd0, hif.rd1_bypass}, 32'h0);
      hif.we_rf_imem = 1'b0; hif.ra1_iexe = 5'd5;
      hif.wa3_imem = 5'd5; hif.wa3_iwb = 5'd5;
      #1 chk("byp_wb_only", {30'd0, hif.rd1_bypass}, 32'h2);
      hif.we_rf_imem = 1'b1; hif.ra2_iexe = 5'd7; hif.wa3_iwb = 5'd7;
      #1 chk("byp_rd2_wb", {30'd0, hif.rd2_bypass}, 32'h2);
      chk("byp_rd1_mem", {30'd0, hif.rd1_bypass}, 32'h1);
      hif.we_rf_iwb = 1'b0;
      #1 chk("byp_rd2_none", {30'd0, hif.rd2_bypass}, 32'h0);
      idle();

      // load-use stall
      cyc();
      hif.load_iexe = 1'b1; hif.we_rf_iexe = 1'b1;
      hif.wa3_iexe = 5'd3; hif.ra2_id = 5'd3;
      #1 chk("lu_stall", ctl(), 32'h31);
      cyc();
      idle();
      #1 chk("lu_cleared", ctl(), 32'h00);
      hif.load_iexe = 1'b0; hif.we_rf_iexe = 1'b1;
      hif.wa3_iexe = 5'd3; hif.ra2_id = 5'd3;
      #1 chk("nonload_none", ctl(), 32'h00);
      hif.load_iexe = 1'b1; hif.wa3_iexe = 5'd0; hif.ra2_id = 5'd0;
      #1 chk("lu_x0_none", ctl(), 32'h00);
      idle();

      // branch beats load-use
      cyc();
      hif.load_iexe = 1'b1; hif.we_rf_iexe = 1'b1;
      hif.wa3_iexe = 5'd9; hif.ra1_id = 5'd9; hif.branch_taken = 1'b1;
      #1 chk("br_over_lu", ctl(), 32'h03);
      cyc();
      idle();
      #1 chk("br_done", ctl(), 32'h00);

      // memory wait, branch pulsed in its second cycle
      n_stall = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         hif.lsu_busy = 1'b1;
         hif.branch_taken = (i == 1);
         #1;
         if (ctl() == 32'h3C) n_stall++;
         chk("mw_noflush", {30'd0, hif.flush_iid, hif.flush_iexe}, 32'h0);
      end
      cyc();
      hif.lsu_busy = 1'b0; hif.branch_taken = 1'b0;
      #1 chk("mw_release", ctl(), 32'h00);
      chk("mw_stall_cycles", n_stall, 32'd4);
      cyc();
      #1 chk("mw_pend_flush", ctl(), 32'h03);
      cyc();
      #1 chk("mw_after_flush", ctl(), 32'h00);

      // timeout watchdog
      n_stall = 0; n_tmo = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         hif.lsu_busy = 1'b1;
         #1;
         if (ctl() == 32'h3C) n_stall++;
         if (hif.lsu_tmo) n_tmo++;
         if (i == 64) chk("tmo_last_stall", {ctl()[5:0], 1'b0, hif.lsu_tmo}, {6'h3C, 2'b00});
         if (i == 65) chk("tmo_first", {ctl()[5:0], 1'b0, hif.lsu_tmo}, {6'h00, 2'b01});
      end
      chk("tmo_stall_cycles", n_stall, 32'd65);
      chk("tmo_flag_cycles", n_tmo, 32'd35);
      cyc();
      hif.lsu_busy = 1'b0;
      #1 chk("tmo_busy_fall", {31'd0, hif.lsu_tmo}, 32'd1);
      cyc();
      #1 chk("tmo_cleared", {ctl()[5:0], 1'b0, hif.lsu_tmo}, 32'h0);

      // async reset in the middle of a memory wait with a pending flush
      cyc();
      hif.lsu_busy = 1'b1;
      cyc();
      hif.branch_taken = 1'b1;
      cyc();
      hif.branch_taken = 1'b0;
      #2;
      rst = 1'b1; hif.lsu_busy = 1'b0;
      #1 chk("rst_mid_ctl", ctl(), 32'h00);
      cyc();
      rst = 1'b0;
      #1 chk("rst_rel_ctl", ctl(), 32'h00);
      cyc();
      #1 chk("rst_no_flush", ctl(), 32'h00);

`ifdef NF_HU_PERF_CNT_EN
      chk("perf_rst_lu", hif.lu_stall_cnt, 32'd0);
      chk("perf_rst_mem", hif.mem_stall_cnt, 32'd0);
      hif.load_iexe = 1'b1; hif.we_rf_iexe = 1'b1;
      hif.wa3_iexe = 5'd4; hif.ra1_id = 5'd4;
      cyc();
      idle();
      hif.lsu_busy = 1'b1;
      cyc();
      cyc();
      hif.lsu_busy = 1'b0;
      cyc();
      #1 chk("perf_lu", hif.lu_stall_cnt, 32'd1);
      chk("perf_mem", hif.mem_stall_cnt, 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
